// File: rtl/ram_pkg.sv
// Shared types and helpers for the sync RAM bank.
// No logic state; no latency; no flow control.
// Pure package, no handshake.
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Widest word the merge helper handles; callers cast in and out.
  localparam int MERGE_W = 512;

  function automatic logic [MERGE_W-1:0] be_merge(
    input logic [MERGE_W-1:0]   old_d,
    input logic [MERGE_W-1:0]   new_d,
    input logic [MERGE_W/8-1:0] be
  );
    logic [MERGE_W-1:0] r;
    r = old_d;
    for (int i = 0; i < MERGE_W / 8; i++) begin
      if (be[i]) r[8*i +: 8] = new_d[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_ram_bank_rd_pipe.sv
// Read response pipeline: carries {valid, err, addr, data} to the response port.
// Latency RD_LAT (1 or 2) cycles from accept; one read per cycle.
// No backpressure: responses are strobed out unconditionally.
module ram_rd_pipe
  import ram_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = RDW_READ_FIRST
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                acc_vld,
  input  logic                acc_err,
  input  logic [ADDR_W-1:0]   acc_addr,
  input  logic [DATA_W-1:0]   arr_dat,
  input  logic                pend_vld,
  input  logic [ADDR_W-1:0]   pend_addr,
  input  logic [DATA_W-1:0]   pend_dat,
  input  logic [DATA_W/8-1:0] pend_be,
  output logic                rsp_valid,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   rsp_rdata
);

  logic                s1_vld;
  logic                s1_err;
  logic [DATA_W-1:0]   s1_dat;
  logic [ADDR_W-1:0]   s1_addr;
  logic                s1_pvld;
  logic [ADDR_W-1:0]   s1_paddr;
  logic [DATA_W-1:0]   s1_pdat;
  logic [DATA_W/8-1:0] s1_pbe;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_err <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= acc_vld;
      s1_err <= acc_vld && acc_err;
      if (acc_vld) s1_dat <= acc_err ? '0 : arr_dat;
    end
  end

  // Snapshot of the write still waiting to commit when this read sampled the array.
  always_ff @(posedge clk) begin
    if (acc_vld) begin
      s1_addr  <= acc_addr;
      s1_pvld  <= pend_vld;
      s1_paddr <= pend_addr;
      s1_pdat  <= pend_dat;
      s1_pbe   <= pend_be;
    end
  end

  if (RD_LAT == 1) begin : g_lat1
    logic unused_fwd;
    assign unused_fwd = ^{s1_addr, s1_pvld, s1_paddr, s1_pdat, s1_pbe};
    assign rsp_valid  = s1_vld;
    assign rsp_err    = s1_err;
    assign rsp_rdata  = s1_dat;
  end else begin : g_lat2
    logic              s1_hit;
    logic [DATA_W-1:0] s1_fwd;
    logic              o_vld;
    logic              o_err;
    logic [DATA_W-1:0] o_dat;

    assign s1_hit = s1_pvld && (s1_paddr == s1_addr);
    assign s1_fwd = DATA_W'(be_merge(MERGE_W'(s1_dat), MERGE_W'(s1_pdat), (MERGE_W/8)'(s1_pbe)));

    always_ff @(posedge clk) begin
      if (rst) begin
        o_vld <= 1'b0;
        o_err <= 1'b0;
        o_dat <= '0;
      end else begin
        o_vld <= s1_vld;
        o_err <= s1_err;
        if (s1_vld) begin
          o_dat <= (RDW_MODE == RDW_WRITE_FIRST && s1_hit && !s1_err) ? s1_fwd : s1_dat;
        end
      end
    end

    assign rsp_valid = o_vld;
    assign rsp_err   = o_err;
    assign rsp_rdata = o_dat;
  end

endmodule

// File: rtl/sync_ram_bank.sv
// Single-port RAM bank with byte-enable writes, clear engine and valid/ready request port.
// Read latency RD_LAT cycles; writes give no response.
// req_ready low while the clear engine runs; no response backpressure.
module sync_ram_bank
  import ram_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int DEPTH    = 56,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = RDW_READ_FIRST
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_req,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;
  localparam int AIW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

  state_e            state;
  state_e            state_nxt;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] clr_addr_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic              accept;
  logic              acc_rd;
  logic              acc_wr;
  logic [DATA_W-1:0] arr_rdata;

  logic              wr_en;
  logic [AIW-1:0]    wr_idx;
  logic [DATA_W-1:0] wr_dat;
  logic [BE_W-1:0]   wr_be;

  logic              pend_vld;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_dat;
  logic [BE_W-1:0]   pend_be;

  assign in_range  = ({1'b0, req_addr} < DEPTH_V);
  assign req_ready = (state == ST_READY) && !rst;
  assign busy      = (state == ST_CLEAR);
  assign accept    = req_valid && req_ready;
  assign acc_rd    = accept && !req_we;
  assign acc_wr    = accept && req_we && in_range;
  assign arr_rdata = in_range ? mem[req_addr[AIW-1:0]] : '0;

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    case (state)
      ST_CLEAR: begin
        clr_addr_nxt = clr_addr + 1'b1;
        if (clr_addr == CLR_LAST) begin
          state_nxt    = ST_READY;
          clr_addr_nxt = '0;
        end
      end
      ST_READY: begin
        if (clr_req) begin
          state_nxt    = ST_CLEAR;
          clr_addr_nxt = '0;
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  // A staged write may commit in the first clear cycle; the clear write is last so it wins.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_dat[8*i +: 8];
      end
    end
    if (state == ST_CLEAR) mem[clr_addr[AIW-1:0]] <= '0;
  end

  if (RD_LAT == 1) begin : g_wr_direct
    assign wr_en     = acc_wr;
    assign wr_idx    = req_addr[AIW-1:0];
    assign wr_dat    = req_wdata;
    assign wr_be     = req_be;
    assign pend_vld  = 1'b0;
    assign pend_addr = '0;
    assign pend_dat  = '0;
    assign pend_be   = '0;
  end else begin : g_wr_staged
    // Writes sit one cycle in a staging register so a following read can pick old or new data.
    always_ff @(posedge clk) begin
      if (rst) pend_vld <= 1'b0;
      else     pend_vld <= acc_wr;
      if (acc_wr) begin
        pend_addr <= req_addr;
        pend_dat  <= req_wdata;
        pend_be   <= req_be;
      end
    end
    assign wr_en  = pend_vld;
    assign wr_idx = pend_addr[AIW-1:0];
    assign wr_dat = pend_dat;
    assign wr_be  = pend_be;
  end

  ram_rd_pipe #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .RD_LAT   (RD_LAT),
    .RDW_MODE (RDW_MODE)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .acc_vld   (acc_rd),
    .acc_err   (!in_range),
    .acc_addr  (req_addr),
    .arr_dat   (arr_rdata),
    .pend_vld  (pend_vld),
    .pend_addr (pend_addr),
    .pend_dat  (pend_dat),
    .pend_be   (pend_be),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata)
  );

endmodule

// File: tb/tb_sync_ram_bank.sv
// Scoreboard bench for sync_ram_bank: three instances (RD_LAT=1; RD_LAT=2 read-first; RD_LAT=2 write-first)
// share one stimulus stream; each has its own expected-response queue checked by a monitor.
module tb_sync_ram_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        clr_req;
  logic        req_valid;
  logic        req_we;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic [2:0]  rdy;
  logic [2:0]  rv;
  logic [2:0]  re;
  logic [2:0]  bz;
  logic [31:0] rdat [3];

  sync_ram_bank #(.RD_LAT(1), .RDW_MODE(0)) u_l1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv[0]), .rsp_rdata(rdat[0]), .rsp_err(re[0]), .busy(bz[0]));

  sync_ram_bank #(.RD_LAT(2), .RDW_MODE(0)) u_rf (
    .clk(clk), .rst(rst), .clr_req(clr_req), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv[1]), .rsp_rdata(rdat[1]), .rsp_err(re[1]), .busy(bz[1]));

  sync_ram_bank #(.RD_LAT(2), .RDW_MODE(1)) u_wf (
    .clk(clk), .rst(rst), .clr_req(clr_req), .req_valid(req_valid), .req_ready(rdy[2]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv[2]), .rsp_rdata(rdat[2]), .rsp_err(re[2]), .busy(bz[2]));

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          c;
  } exp_t;

  exp_t q [3][$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic mon(input int i);
    exp_t x;
    if (rv[i] !== 1'b1) return;
    n_chk++;
    if (q[i].size() == 0) begin
      n_fail++;
      $display("FAIL rsp_unexpected dut%0d: rsp_valid=1 data=0x%08h at cycle %0d, no response expected",
               i, rdat[i], cyc);
      return;
    end
    x = q[i].pop_front();
    if (rdat[i] !== x.d || re[i] !== x.e || cyc != x.c) begin
      n_fail++;
      $display("FAIL rsp dut%0d: got data=0x%08h err=%0b cycle=%0d, expected data=0x%08h err=%0b cycle=%0d",
               i, rdat[i], re[i], cyc, x.d, x.e, x.c);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) mon(i);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    step();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] d0, input logic [31:0] d1,
                    input logic [31:0] d2, input logic e, input logic [2:0] m);
    exp_t x;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    req_wdata = '0;
    req_be    = '0;
    for (int i = 0; i < 3; i++) begin
      if (m[i]) begin
        x.d = (i == 0) ? d0 : (i == 1) ? d1 : d2;
        x.e = e;
        x.c = cyc + lat(i);
        q[i].push_back(x);
      end
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic count_busy(input int pulse_at, output int n);
    n = 0;
    while (bz[0] === 1'b1 && n < 300) begin
      if (n == pulse_at) clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst       = 1'b1;
    clr_req   = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    idle(3);

    check("reset_req_ready", 32'(rdy), 32'h0);
    check("reset_busy", 32'(bz), 32'h7);
    check("reset_rsp_valid", 32'(rv), 32'h0);
    check("reset_rsp_err", 32'(re), 32'h0);
    check("reset_rsp_rdata_l1", rdat[0], 32'h0);
    check("reset_rsp_rdata_rf", rdat[1], 32'h0);

    rst = 1'b0;
    count_busy(-1, n);
    check("clear_cycles_after_reset", 32'(n), 32'd56);
    check("ready_after_clear", 32'(rdy), 32'h7);

    rd(6'd0,  32'h0, 32'h0, 32'h0, 1'b0, 3'b111);
    rd(6'd27, 32'h0, 32'h0, 32'h0, 1'b0, 3'b111);
    rd(6'd55, 32'h0, 32'h0, 32'h0, 1'b0, 3'b111);
    idle(3);

    wr(6'd5, 32'hDEADBEEF, 4'b1111);
    wr(6'd5, 32'h00001234, 4'b0011);
    idle(1);
    rd(6'd5, 32'hDEAD1234, 32'hDEAD1234, 32'hDEAD1234, 1'b0, 3'b111);
    idle(3);

    wr(6'd1, 32'hA1A1A1A1, 4'b1111);
    wr(6'd2, 32'hB2B2B2B2, 4'b1111);
    wr(6'd3, 32'hC3C3C3C3, 4'b1111);
    idle(1);
    rd(6'd1, 32'hA1A1A1A1, 32'hA1A1A1A1, 32'hA1A1A1A1, 1'b0, 3'b111);
    rd(6'd2, 32'hB2B2B2B2, 32'hB2B2B2B2, 32'hB2B2B2B2, 1'b0, 3'b111);
    rd(6'd3, 32'hC3C3C3C3, 32'hC3C3C3C3, 32'hC3C3C3C3, 1'b0, 3'b111);
    idle(3);

    wr(6'd9, 32'h11111111, 4'b1111);
    idle(1);
    wr(6'd9, 32'h22222222, 4'b1111);
    rd(6'd9, 32'h22222222, 32'h11111111, 32'h22222222, 1'b0, 3'b111);
    wr(6'd9, 32'h33333333, 4'b0101);
    rd(6'd9, 32'h22332233, 32'h22222222, 32'h22332233, 1'b0, 3'b111);
    idle(1);
    rd(6'd9, 32'h22332233, 32'h22332233, 32'h22332233, 1'b0, 3'b111);
    idle(3);

    wr(6'd4, 32'h44444444, 4'b1111);
    idle(1);
    rd(6'd60, 32'h0, 32'h0, 32'h0, 1'b1, 3'b111);
    wr(6'd60, 32'hFFFFFFFF, 4'b1111);
    idle(1);
    rd(6'd4, 32'h44444444, 32'h44444444, 32'h44444444, 1'b0, 3'b111);
    idle(3);

    rd(6'd5, 32'hDEAD1234, 32'h0, 32'h0, 1'b0, 3'b001);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    count_busy(20, n);
    check("clear_cycles_after_midrun_reset", 32'(n), 32'd56);
    check("ready_after_midrun_reset", 32'(rdy), 32'h7);
    rd(6'd5, 32'h0, 32'h0, 32'h0, 1'b0, 3'b111);
    idle(3);

    wr(6'd7, 32'h77777777, 4'b1111);
    idle(1);
    rd(6'd7, 32'h77777777, 32'h77777777, 32'h77777777, 1'b0, 3'b111);
    clr_req = 1'b1;
    rd(6'd7, 32'h77777777, 32'h77777777, 32'h77777777, 1'b0, 3'b111);
    clr_req = 1'b0;
    check("busy_after_clr_req", 32'(bz), 32'h7);
    count_busy(-1, n);
    check("clear_cycles_after_clr_req", 32'(n), 32'd56);
    rd(6'd7, 32'h0, 32'h0, 32'h0, 1'b0, 3'b111);
    idle(5);

    check("pending_rsp_l1", 32'(q[0].size()), 32'd0);
    check("pending_rsp_rf", 32'(q[1].size()), 32'd0);
    check("pending_rsp_wf", 32'(q[2].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_ram_bank.md
Name: sync_ram_bank

Overview:
- Parametrised single-port synchronous RAM bank for the processor memory path.
- Successor to the fixed 32-bit tristate RAM.
- Separate write/read data buses replace the bidirectional bus, with byte-enable writes, configurable read latency (1 or 2) and a selectable read-during-write policy.
- Built-in clear engine zeroes the array after reset or on request.
- A valid/ready request port and a response valid strobe replace cs/we/oe.

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- ADDR_W, 6, address width in bits.
- DEPTH, 56, number of words; must satisfy DEPTH <= 2**ADDR_W.
- RD_LAT, 1, read latency in cycles from accept to rsp_valid; legal values 1 or 2.
- RDW_MODE, 0, read-during-write policy; 0 = read-first (return old data), 1 = write-first (return merged new data).

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous active-high reset.
- clr_req  input  1  pulse; restarts the clear engine.
- req_valid  input  1  request present.
- req_ready  output  1  bank can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  write data.
- req_be  input  DATA_W/8  byte enables for writes.
- rsp_valid  output  1  read data valid strobe.
- rsp_rdata  output  DATA_W  read data.
- rsp_err  output  1  qualifies rsp_valid; the read address was out of range.
- busy  output  1  clear engine is active.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=1.
  - The FSM enters CLEAR with clr_addr=0.
  - Array contents are not reset directly; the clear engine zeroes them.
- FSM states:
  - CLEAR: writes 0 to mem[clr_addr] each cycle and increments clr_addr.
    - When clr_addr==DEPTH-1, that write completes and the FSM moves to READY next cycle.
    - busy=1 and req_ready=0 throughout CLEAR.
    - A full clear takes DEPTH cycles.
  - READY: req_ready=1 and busy=0.
    - clr_req=1 moves the FSM to CLEAR with clr_addr=0 next cycle.
    - A request in the same cycle as clr_req is still accepted (ready is already high).
- Accept: a request is accepted when req_valid & req_ready.
- Write: on accept, for each byte i with req_be[i]=1, mem[addr] byte i takes req_wdata byte i.
  - Bytes with req_be=0 are unchanged.
  - Writes produce no response.
- Read: on accept at edge T, rsp_valid=1 for exactly one cycle after edge T+RD_LAT.
  - rsp_rdata holds the data in that cycle.
  - With RD_LAT=2 an output register is added; back-to-back reads keep full throughput, one per cycle.
  - There is no backpressure on the response side.
- Out-of-range (req_addr >= DEPTH):
  - Writes are dropped.
  - Reads return rsp_rdata=0 with rsp_err=1, using the same latency.
- Read-during-write: one request per cycle means a collision is a read accepted the cycle after a write to the same address while the write is still in the RAM pipeline (RD_LAT=2 only).
  - RDW_MODE=0: the read returns the pre-write value.
  - RDW_MODE=1: the read returns the post-write value with byte-enable merge.
  - With RD_LAT=1, reads always see all prior writes.
- rsp_rdata holds its last value when rsp_valid=0.
- rst mid-operation:
  - In-flight read responses are squashed; no rsp_valid after reset.
  - The FSM re-enters CLEAR.
  - A partially cleared array is cleared again from address 0.
- clr_req during CLEAR is ignored; the current clear runs to completion.

Decomposition:
- Package ram_pkg:
  - FSM state enum (ST_CLEAR, ST_READY).
  - RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1 constants.
  - Helper function for byte-enable merge (old, new, be).
- Sub-module ram_rd_pipe: RD_LAT-deep shift register of {valid, err, addr}, plus the optional output data register and RDW bypass compare.
- Top level holds the array, the clear FSM and the accept logic.

Test Plan:
- Reset release -> busy=1 and req_ready=0 for exactly 56 cycles; then req_ready=1; reads of addr 0, 27 and 55 return 0x00000000.
- Write addr 5 data 0xDEADBEEF be=4'b1111, then write addr 5 data 0x00001234 be=4'b0011, then read addr 5 -> rsp_valid after RD_LAT cycles with 0xDEAD1234 and rsp_err=0.
- RD_LAT=2: reads of addr 1, 2, 3 on consecutive cycles -> rsp_valid high for 3 consecutive cycles, data in request order.
- RD_LAT=2, mem[9]=0x11111111: write 0x22222222 to addr 9, read addr 9 next cycle -> returns 0x11111111 with RDW_MODE=0; returns 0x22222222 with RDW_MODE=1.
- Read addr 60 (>= DEPTH=56) -> rsp_valid=1, rsp_err=1, rsp_rdata=0; write to addr 60 then read addr 4 -> mem[4] unchanged.
- Accept a read, then assert rst one cycle later -> no rsp_valid; busy=1 for 56 cycles; clr_req in READY -> busy high again and previously written data reads back 0.
